rr_arb8_using_pe: RTL and testbench

Round-robin arbiter that shares one resource among 8 requesters. It uses 8-to-3 priority encoding (highest index wins) on a rotating request mask. A grant is held until the owner signals `done`, drops its request, or exceeds a hold limit. A one-cycle turnaround separates consecutive grants. It sits between requesting blocks and the shared resource and drives the resource's select lines.

---
 rtl/rr_arb8_using_pe_pkg.sv | 19 +
 rtl/rr_arb8_using_pe_mask_pick8.sv | 34 +++
 rtl/rr_arb8_using_pe.sv | 106 ++++++++++
 tb/tb_rr_arb8_using_pe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb8_using_pe_pkg.sv
// Shared definitions for the 8-requester round-robin arbiter.
//   state_e      : FSM encoding (IDLE/GRANT/GAP)
//   HOLD_MAX_DEF : default maximum grant length in cycles
//   dec8()       : 3-bit index to one-hot 8-bit vector
package rr_arb8_using_pe_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GRANT = 2'b01,
    S_GAP   = 2'b10
  } state_e;

  localparam int HOLD_MAX_DEF = 16;

  function automatic logic [7:0] dec8(input logic [2:0] id);
    return 8'(1) << id;
  endfunction

endpackage

// File: rtl/rr_arb8_using_pe_mask_pick8.sv
// Winner selection for the round-robin arbiter.
//   pe8to3     : 8-to-3 priority encoder, highest set index wins,
//                idle_o high when the input is all zero.
//   mask_pick8 : picks the highest index of req & mask; if that is empty,
//                falls back to the highest index of req.
//   Ports (mask_pick8): req[7:0], mask[7:0] in; win_id[2:0], none out.
module pe8to3 (
  input  logic [7:0] in_i,
  output logic [2:0] id_o,
  output logic       idle_o
);
  always_comb begin
    id_o = 3'd0;
    for (int i = 0; i < 8; i++)
      if (in_i[i]) id_o = 3'(i);
  end
  assign idle_o = ~|in_i;
endmodule

module mask_pick8 (
  input  logic [7:0] req,
  input  logic [7:0] mask,
  output logic [2:0] win_id,
  output logic       none
);
  logic [2:0] m_id, f_id;
  logic       m_idle, f_idle;

  pe8to3 u_pe_masked (.in_i(req & mask), .id_o(m_id), .idle_o(m_idle));
  pe8to3 u_pe_full   (.in_i(req),        .id_o(f_id), .idle_o(f_idle));

  assign win_id = m_idle ? f_id : m_id;
  assign none   = f_idle;
endmodule

// File: rtl/rr_arb8_using_pe.sv
// Round-robin arbiter sharing one resource among 8 requesters.
// A grant lasts until done, until the owner drops its request, or until
// HOLD_MAX cycles have elapsed; one idle cycle separates grants.
//   clk, rst      : clock, asynchronous active-high reset
//   req[7:0]      : level request per requester
//   done          : release pulse from the resource (ignored outside GRANT)
//   gnt[7:0]      : registered one-hot grant, zero when none
//   gnt_id[2:0]   : index of current / most recent grant
//   busy          : high while a grant is held
//   timeout       : one-cycle pulse in the gap after a forced release
// HOLD_MAX must lie in 2..2^CW-1 so the counter never wraps.
module rr_arb8_using_pe
  import rr_arb8_using_pe_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int CW       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      mask_q, mask_d;
  logic [7:0]      gnt_q, gnt_d;
  logic [2:0]      id_q, id_d;
  logic            to_q, to_d;

  logic [2:0]      win_id;
  logic            none;
  logic            at_max, rel;

  mask_pick8 u_pick (.req(req), .mask(mask_q), .win_id(win_id), .none(none));

  assign at_max = (cnt_q == CW'(HOLD_MAX - 1));
  assign rel    = done | ~req[id_q] | at_max;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    to_d    = 1'b0;
    case (state_q)
      // IDLE and GAP arbitrate identically; GAP just sees the freshly
      // rotated mask.
      S_IDLE, S_GAP: begin
        if (!none) begin
          state_d = S_GRANT;
          gnt_d   = dec8(win_id);
          id_d    = win_id;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end
      end
      S_GRANT: begin
        cnt_d = cnt_q + 1'b1;
        if (rel) begin
          state_d = S_GAP;
          gnt_d   = '0;
          // Favour only indices below the last winner; 0 gives an empty mask.
          mask_d  = dec8(id_q) - 8'd1;
          // Timeout only if neither done nor abandon took precedence.
          to_d    = ~done & req[id_q];
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mask_q  <= 8'hFF;
      gnt_q   <= '0;
      id_q    <= 3'd0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      to_q    <= to_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = id_q;
  assign busy    = (state_q == S_GRANT);
  assign timeout = to_q;

endmodule

// File: tb/tb_rr_arb8_using_pe.sv
module tb_rr_arb8_using_pe;
  localparam int HOLD_MAX = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       busy, timeout;

  rr_arb8_using_pe #(.HOLD_MAX(HOLD_MAX), .CW(5)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cmp_n  = 0;
  int fail_n = 0;

  // Reference model: who owns the resource, how long it has held it, and
  // the threshold below which requesters are favoured. A released resource
  // is simply unowned for the next edge; arbitration happens on any edge
  // where nobody owns it.
  int   m_owner, m_held, m_thresh, m_last;
  logic m_to;

  function automatic int pick(input logic [7:0] r, input int th);
    for (int i = 7; i >= 0; i--) if (r[i] && i < th) return i;
    for (int i = 7; i >= 0; i--) if (r[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_thresh = 8; m_last = 0; m_to = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic d);
    int w;
    if (m_owner >= 0) begin
      m_held++;
      if (d || !r[m_owner] || m_held == HOLD_MAX) begin
        m_to     = !d && r[m_owner] && (m_held == HOLD_MAX);
        m_thresh = m_owner;
        m_owner  = -1;
      end else m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      w = pick(r, m_thresh);
      if (w >= 0) begin m_owner = w; m_held = 0; m_last = w; end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [7:0] eg;
    eg = (m_owner >= 0) ? (8'(1) << m_owner) : 8'h00;
    check("m_gnt", 32'(gnt), 32'(eg));
    check("m_busy", 32'(busy), 32'(m_owner >= 0));
    check("m_timeout", 32'(timeout), 32'(m_to));
    if (m_owner >= 0) check("m_gnt_id", 32'(gnt_id), 32'(m_last));
    check("onehot0", 32'($onehot0(gnt)), 32'd1);
    if (busy) check("gnt_vs_id", 32'(gnt), 32'(8'(1) << gnt_id));
  endtask

  task automatic step(input logic [7:0] r, input logic d);
    req = r; done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
  endtask

  task automatic do_reset();
    req = 8'h00; done = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       busy;
    logic       to;
  } vec_t;
  vec_t tv[10];
  int   rr_order[9];

  initial begin
    tv[0] = '{8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
    tv[1] = '{8'h81, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0};
    tv[2] = '{8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    tv[3] = '{8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    tv[4] = '{8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
    tv[5] = '{8'h00, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0};
    tv[6] = '{8'h00, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0};
    tv[7] = '{8'h84, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
    tv[8] = '{8'h84, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0};
    tv[9] = '{8'h84, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
    rr_order = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

    // Reset state
    do_reset();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_id", 32'(gnt_id), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      step(tv[i].req, tv[i].done);
      check($sformatf("tv%0d_gnt", i), 32'(gnt), 32'(tv[i].gnt));
      check($sformatf("tv%0d_id", i), 32'(gnt_id), 32'(tv[i].id));
      check($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].busy));
      check($sformatf("tv%0d_to", i), 32'(timeout), 32'(tv[i].to));
      check_model();
    end

    // Round-robin rotation with req=FF, done after three grant cycles
    do_reset();
    for (int g = 0; g < 9; g++) begin
      step(8'hFF, 1'b0);
      check($sformatf("rr%0d_gnt", g), 32'(gnt), 32'(8'(1) << rr_order[g]));
      step(8'hFF, 1'b0);
      step(8'hFF, 1'b0);
      step(8'hFF, 1'b1);
      check($sformatf("rr%0d_gap", g), 32'(gnt), 32'h0);
      check_model();
    end

    // Timeout: sole requester held for HOLD_MAX cycles
    do_reset();
    for (int c = 0; c < HOLD_MAX; c++) begin
      step(8'h10, 1'b0);
      check($sformatf("hold%0d", c), 32'(gnt), 32'h10);
      check("hold_to", 32'(timeout), 32'h0);
    end
    step(8'h10, 1'b0);
    check("to_gnt", 32'(gnt), 32'h0);
    check("to_pulse", 32'(timeout), 32'h1);
    step(8'h10, 1'b0);
    check("to_regrant", 32'(gnt), 32'h10);
    check("to_clear", 32'(timeout), 32'h0);

    // done coincident with the last allowed cycle: normal release
    do_reset();
    for (int c = 0; c < HOLD_MAX; c++) step(8'h10, 1'b0);
    step(8'h10, 1'b1);
    check("done_max_gnt", 32'(gnt), 32'h0);
    check("done_max_to", 32'(timeout), 32'h0);

    // Abandon: drop req[4] with req[2] still pending
    do_reset();
    step(8'h14, 1'b0);
    check("ab_gnt4", 32'(gnt), 32'h10);
    step(8'h14, 1'b0);
    step(8'h04, 1'b0);
    check("ab_gap", 32'(gnt), 32'h0);
    check("ab_to", 32'(timeout), 32'h0);
    step(8'h04, 1'b0);
    check("ab_gnt2", 32'(gnt), 32'h04);

    // Asynchronous reset mid-grant
    step(8'h04, 1'b0);
    check("pre_rst_gnt", 32'(gnt), 32'h04);
    #2 rst = 1'b1;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    model_reset();
    req = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    step(8'h0C, 1'b0);
    check("post_rst_gnt", 32'(gnt), 32'h08);
    check("post_rst_id", 32'(gnt_id), 32'h3);

    // Random run against the model
    do_reset();
    begin
      logic [7:0] r;
      r = 8'h00;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 7) == 0) r = 8'($urandom);
        step(r, ($urandom_range(0, 5) == 0));
        check_model();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
